// File: rtl/usb_pkg.sv
// Shared definitions for the USB receive deframer: sync marker, error
// encodings, state encoding and a saturating counter helper.
package usb_pkg;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_SUM  = 2'b10;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAILER = 2'd2
    } rx_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep AXI-Stream register slice: the upstream sees ready whenever
// the single holding register is empty or is being drained this cycle.
module axis_reg_slice #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_last_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o
);

    logic          valid_q;
    logic          last_q;
    logic [DW-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

    // Load on an upstream handshake, otherwise empty once downstream takes the word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            last_q  <= in_last_i;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/usb_rx_deframer.sv
// Receive deframer: hunts for {SYNC_WORD, LEN} headers, forwards LEN
// payload words through a one-deep output slice, then checks the trailer
// against the running mod-2^32 sum. Only 4-byte words are supported.
module usb_rx_deframer
    import usb_pkg::*;
#(
    parameter int          TDATA_WIDTH = 4,
    parameter int          MAX_LEN     = 1024,
    parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEF
) (
    input  logic                     rx_clk,
    input  logic                     rst_glbl,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [8*TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [TDATA_WIDTH-1:0]   s_axis_tkeep,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [8*TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TDATA_WIDTH-1:0]   m_axis_tkeep,
    output logic [TDATA_WIDTH-1:0]   m_axis_tstrb,
    output logic                     m_axis_tlast,
    output logic                     frame_done,
    output logic                     frame_err,
    output logic [1:0]               err_code,
    output logic [15:0]              frame_cnt,
    output logic [15:0]              err_cnt
);

    localparam int          DW        = 8 * TDATA_WIDTH;
    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

    rx_state_e     state_q;
    logic [15:0]   cnt_q;
    logic [DW-1:0] acc_q;
    logic          done_q;
    logic          err_q;
    logic [1:0]    code_q;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   err_cnt_q,   err_cnt_d;

    logic          slice_rdy;
    logic          accept;
    logic          hdr_sync;
    logic          len_ok;
    logic          sum_ok;
    logic          inc_frame;
    logic          inc_err;

    // Framing side-band on the input is not used; the header carries the length.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, s_axis_tkeep, s_axis_tlast};

    // Payload waits on the output slice; header and trailer are always taken.
    assign s_axis_tready = !rst_glbl && ((state_q == ST_PAYLOAD) ? slice_rdy : 1'b1);
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign hdr_sync  = (s_axis_tdata[31:16] == SYNC_WORD);
    assign len_ok    = (s_axis_tdata[15:0] != 16'd0) && ({1'b0, s_axis_tdata[15:0]} <= MAX_LEN_W);
    assign sum_ok    = (s_axis_tdata == acc_q);
    assign inc_frame = (state_q == ST_TRAILER) && accept && sum_ok;
    assign inc_err   = ((state_q == ST_HUNT) && accept && hdr_sync && !len_ok) ||
                       ((state_q == ST_TRAILER) && accept && !sum_ok);

    axis_reg_slice #(
        .DW(DW)
    ) u_out_slice (
        .clk_i       (rx_clk),
        .rst_i       (rst_glbl),
        .in_valid_i  ((state_q == ST_PAYLOAD) && s_axis_tvalid),
        .in_ready_o  (slice_rdy),
        .in_data_i   (s_axis_tdata),
        .in_last_i   (cnt_q == 16'd1),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready),
        .out_data_o  (m_axis_tdata),
        .out_last_o  (m_axis_tlast)
    );

    assign m_axis_tkeep = {TDATA_WIDTH{m_axis_tvalid}};
    assign m_axis_tstrb = {TDATA_WIDTH{m_axis_tvalid}};

    // Frame state machine with word counter, checksum accumulator and status pulses.
    always_ff @(posedge rx_clk or posedge rst_glbl) begin
        if (rst_glbl) begin
            state_q <= ST_HUNT;
            cnt_q   <= 16'd0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_HUNT: begin
                    if (accept && hdr_sync) begin
                        if (len_ok) begin
                            cnt_q   <= s_axis_tdata[15:0];
                            acc_q   <= '0;
                            state_q <= ST_PAYLOAD;
                        end else begin
                            err_q  <= 1'b1;
                            code_q <= ERR_LEN;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        acc_q <= acc_q + s_axis_tdata;
                        cnt_q <= cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_q <= ST_TRAILER;
                        end
                    end
                end
                ST_TRAILER: begin
                    if (accept) begin
                        if (sum_ok) begin
                            done_q <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                            code_q <= ERR_SUM;
                        end
                        state_q <= ST_HUNT;
                    end
                end
                default: state_q <= ST_HUNT;
            endcase
        end
    end

    // Next values of the saturating good-frame and error counters.
    always_comb begin
        frame_cnt_d = inc_frame ? sat_inc16(frame_cnt_q) : frame_cnt_q;
        err_cnt_d   = inc_err   ? sat_inc16(err_cnt_q)   : err_cnt_q;
    end

    // Counter registers, updated on the same edge that raises the matching pulse.
    always_ff @(posedge rx_clk or posedge rst_glbl) begin
        if (rst_glbl) begin
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign err_code   = code_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_usb_rx_deframer.sv
// Self-checking bench for usb_rx_deframer: table of frames plus hand-written
// sequences for header errors, mid-frame reset and back-to-back frames.
module tb_usb_rx_deframer;

    logic        rx_clk = 1'b0;
    logic        rst_glbl = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata = 32'd0;
    logic [3:0]  s_axis_tkeep = 4'hF;
    logic        s_axis_tlast = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic [3:0]  m_axis_tstrb;
    logic        m_axis_tlast;
    logic        frame_done;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    usb_rx_deframer dut (
        .rx_clk        (rx_clk),
        .rst_glbl      (rst_glbl),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tlast  (m_axis_tlast),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    int tests = 0;
    int fails = 0;
    logic [32:0] sb_q[$];
    int done_seen = 0;
    int err_seen = 0;
    bit stall_mode = 1'b0;
    bit mon_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [33:0] prev_word = '0;
    int exp_fc = 0;
    int exp_ec = 0;
    logic [1:0] exp_code = 2'b00;

    typedef struct {
        int          len;
        logic [31:0] first;
        bit          bad;
        bit          stall;
    } frame_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready changes just after the active edge.
    always @(posedge rx_clk) begin
        #2;
        m_axis_tready = stall_mode ? ~m_axis_tready : 1'b1;
    end

    // Output monitor: scoreboard pop, hold-while-stalled, keep/strb, pulse counts.
    always @(negedge rx_clk) begin
        if (!rst_glbl && mon_en) begin
            check("keep", m_axis_tkeep, m_axis_tvalid ? 4'hF : 4'h0);
            check("strb", m_axis_tstrb, m_axis_tvalid ? 4'hF : 4'h0);
            if (prev_stall)
                check("hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, prev_word);
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %0h expected no output", m_axis_tdata);
                end else begin
                    check("m_axis_word", {m_axis_tlast, m_axis_tdata}, sb_q.pop_front());
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_word  = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
            if (frame_done) done_seen++;
            if (frame_err)  err_seen++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        bit hs = 1'b0;
        @(negedge rx_clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = w;
        while (!hs && n < 200) begin
            #1;
            hs = s_axis_tready;
            @(posedge rx_clk);
            if (!hs) @(negedge rx_clk);
            n++;
        end
        if (!hs) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: word %0h not accepted, expected handshake", w);
        end
    endtask

    task automatic go_idle();
        @(negedge rx_clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [31:0] first, input bit bad);
        logic [31:0] sum = 32'd0;
        logic [31:0] w;
        send_word({16'hA55A, 16'(len)});
        for (int i = 0; i < len; i++) begin
            w = first + 32'(i);
            sum = sum + w;
            sb_q.push_back({(i == len - 1), w});
            send_word(w);
        end
        send_word(bad ? sum + 32'd1 : sum);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || m_axis_tvalid) && n < 300) begin
            @(negedge rx_clk);
            n++;
        end
        check("drain_left", sb_q.size(), 0);
        repeat (3) @(negedge rx_clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_m_tlast"},  m_axis_tlast, 0);
        check({tag, "_m_tdata"},  m_axis_tdata, 0);
        check({tag, "_s_tready"}, s_axis_tready, 0);
        check({tag, "_done"},     frame_done, 0);
        check({tag, "_err"},      frame_err, 0);
        check({tag, "_code"},     err_code, 0);
        check({tag, "_fcnt"},     frame_cnt, 0);
        check({tag, "_ecnt"},     err_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t frames[5];
        int d0, e0;
        frames[0] = '{len: 3,    first: 32'd1,          bad: 1'b0, stall: 1'b0};
        frames[1] = '{len: 3,    first: 32'd1,          bad: 1'b1, stall: 1'b0};
        frames[2] = '{len: 20,   first: 32'd1,          bad: 1'b0, stall: 1'b1};
        frames[3] = '{len: 3,    first: 32'hFFFF_FFF0,  bad: 1'b0, stall: 1'b1};
        frames[4] = '{len: 1024, first: 32'h1000_0000,  bad: 1'b0, stall: 1'b0};

        repeat (3) @(negedge rx_clk);
        check_reset_state("rst0");
        @(negedge rx_clk);
        rst_glbl = 1'b0;
        mon_en   = 1'b1;
        #1;
        check("hunt_tready", s_axis_tready, 1);

        for (int f = 0; f < 5; f++) begin
            stall_mode = frames[f].stall;
            d0 = done_seen;
            e0 = err_seen;
            send_frame(frames[f].len, frames[f].first, frames[f].bad);
            go_idle();
            wait_drain();
            stall_mode = 1'b0;
            if (frames[f].bad) begin
                exp_ec++;
                exp_code = 2'b10;
            end else begin
                exp_fc++;
            end
            check($sformatf("f%0d_done_pulses", f), done_seen - d0, frames[f].bad ? 0 : 1);
            check($sformatf("f%0d_err_pulses", f),  err_seen - e0,  frames[f].bad ? 1 : 0);
            check($sformatf("f%0d_frame_cnt", f),   frame_cnt, exp_fc);
            check($sformatf("f%0d_err_cnt", f),     err_cnt, exp_ec);
            check($sformatf("f%0d_err_code", f),    err_code, exp_code);
        end

        // Foreign marker, zero length and over-long length headers.
        d0 = done_seen;
        e0 = err_seen;
        send_word(32'h1234_0001);
        send_word(32'hA55A_0000);
        send_word(32'hA55A_0401);
        go_idle();
        repeat (4) @(negedge rx_clk);
        exp_ec += 2;
        check("hdr_err_pulses", err_seen - e0, 2);
        check("hdr_done_pulses", done_seen - d0, 0);
        check("hdr_err_code", err_code, 2'b01);
        check("hdr_err_cnt", err_cnt, exp_ec);
        check("hdr_no_output", sb_q.size(), 0);

        // Reset in the middle of a 5-word frame.
        d0 = done_seen;
        e0 = err_seen;
        send_word(32'hA55A_0005);
        sb_q.push_back({1'b0, 32'd11});
        send_word(32'd11);
        sb_q.push_back({1'b0, 32'd12});
        send_word(32'd12);
        @(negedge rx_clk);
        #3;
        rst_glbl = 1'b1;
        s_axis_tvalid = 1'b0;
        sb_q.delete();
        @(negedge rx_clk);
        check_reset_state("rst_mid");
        @(negedge rx_clk);
        rst_glbl = 1'b0;
        exp_fc = 0;
        exp_ec = 0;
        repeat (2) @(negedge rx_clk);
        check("abort_done_pulses", done_seen - d0, 0);
        check("abort_err_pulses", err_seen - e0, 0);
        send_frame(2, 32'd100, 1'b0);
        go_idle();
        wait_drain();
        check("after_rst_fcnt", frame_cnt, 1);
        check("after_rst_done", done_seen - d0, 1);

        // Two frames with no idle cycle between them.
        d0 = done_seen;
        e0 = err_seen;
        send_frame(2, 32'h0000_0A00, 1'b0);
        send_frame(3, 32'h0000_0B00, 1'b0);
        go_idle();
        wait_drain();
        check("b2b_done_pulses", done_seen - d0, 2);
        check("b2b_err_pulses", err_seen - e0, 0);
        check("b2b_fcnt", frame_cnt, 3);
        check("b2b_ecnt", err_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usb_rx_deframer.md
USB_RX_DEFRAMER -- requirements
Module: usb_rx_deframer

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 4, meaning bytes per AXI-Stream word; only 4 is supported.
REQ-002 SHALL have parameter MAX_LEN, default 1024, meaning the largest legal payload length in words.
REQ-003 SHALL have parameter SYNC_WORD, default 16'hA55A, meaning the header marker carried in header bits [31:16].
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port rx_clk, input, 1 bit: the module clock, the same domain as the ftdi_245fifo_top m_axis side.
REQ-006 SHALL have port rst_glbl, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have ports s_axis_tvalid/tready/tdata[31:0]/tkeep[3:0]/tlast: the input stream from the ftdi_245fifo_top m_axis; tkeep and tlast are ignored.
REQ-008 SHALL have ports m_axis_tvalid/tready/tdata[31:0]/tkeep[3:0]/tstrb[3:0]/tlast: the payload output.
REQ-009 SHALL have port frame_done, output, 1 bit: single-cycle pulse when a frame's checksum matches.
REQ-010 SHALL have port frame_err, output, 1 bit: single-cycle pulse on any frame error.
REQ-011 SHALL have port err_code, output, 2 bits: 01 = bad length, 10 = checksum mismatch; held until the next error.
REQ-012 SHALL have ports frame_cnt and err_cnt, output, 16 bits each: saturating counts of good frames and of errors.

Function
REQ-013 SHALL define the frame format as header {SYNC_WORD, LEN[15:0]}, then LEN payload words, then one trailer word equal to the mod-2^32 sum of the payload.
REQ-014 SHALL implement states HUNT, PAYLOAD and TRAILER; reset state is HUNT.
REQ-015 In HUNT, s_axis_tready SHALL be 1 and every accepted word SHALL be consumed without output.
REQ-016 In HUNT, a word whose bits [31:16] differ from SYNC_WORD SHALL be discarded silently.
REQ-017 In HUNT, a word with the matching marker and 1 <= LEN <= MAX_LEN SHALL load the word counter with LEN, clear the checksum accumulator and move to PAYLOAD.
REQ-018 In HUNT, a word with the matching marker and LEN = 0 or LEN > MAX_LEN SHALL pulse frame_err, set err_code = 01, increment err_cnt and stay in HUNT.
REQ-019 In PAYLOAD, s_axis_tready SHALL equal (!m_axis_tvalid || m_axis_tready), i.e. a one-deep register slice.
REQ-020 In PAYLOAD, each accepted word SHALL appear on m_axis exactly one cycle later.
REQ-021 In PAYLOAD, each accepted word SHALL be added to the accumulator and decrement the counter.
REQ-022 m_axis_tlast SHALL be 1 only on the word for which the counter reaches 0, and the state SHALL then move to TRAILER.
REQ-023 m_axis_tkeep and m_axis_tstrb SHALL be 4'hF whenever m_axis_tvalid is 1, and 0 otherwise.
REQ-024 m_axis_tdata, tvalid and tlast SHALL be held stable while tvalid=1 and tready=0.
REQ-025 In TRAILER, s_axis_tready SHALL be 1.
REQ-026 In TRAILER, an accepted word equal to the accumulator SHALL pulse frame_done and increment frame_cnt.
REQ-027 In TRAILER, an accepted word not equal to the accumulator SHALL pulse frame_err, set err_code = 10 and increment err_cnt.
REQ-028 In TRAILER, either outcome SHALL return the state to HUNT on the next cycle.
REQ-029 Payload SHALL NOT be withheld pending the checksum; a bad checksum is signalled only through frame_err.
REQ-030 frame_cnt and err_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-031 The pending m_axis word SHALL still drain when the state changes to TRAILER or HUNT.
REQ-032 The next header SHALL be accepted while the last payload word is still waiting on m_axis.
REQ-033 The accumulator SHALL be 32 bits and wrap modulo 2^32.
REQ-034 The word counter SHALL be 16 bits wide.

Reset
REQ-035 While rst_glbl=1, m_axis_tvalid, m_axis_tlast, frame_done, frame_err, err_code, frame_cnt and err_cnt SHALL be 0.
REQ-036 While rst_glbl=1, m_axis_tdata SHALL be 0, s_axis_tready SHALL be 0 and the state SHALL be HUNT.
REQ-037 A reset asserted mid-frame SHALL discard the partial frame with no pulse on frame_done or frame_err.
REQ-038 After reset deasserts, the block SHALL resume in HUNT on the first rx_clk edge.

Structure
REQ-039 A shared package usb_pkg SHALL hold SYNC_WORD, the err_code encodings and the state encoding.
REQ-040 One sub-module, axis_reg_slice (one-deep valid/ready register), SHALL implement the m_axis output stage; the state machine, counter and accumulator SHALL stay in usb_rx_deframer.

Verification
REQ-041 Send header 32'hA55A_0003, payload 1,2,3, trailer 6, with m_axis_tready=1 -> m_axis outputs 1,2,3 with tlast on 3; frame_done pulses once; frame_cnt=1.
REQ-042 Repeat REQ-041 with trailer 7 -> payload still delivered; frame_err pulses; err_code=10; err_cnt=1; frame_cnt unchanged.
REQ-043 Send 32'h1234_0001, then 32'hA55A_0000, then 32'hA55A_0401 -> no m_axis output; two frame_err pulses with err_code=01; err_cnt=2.
REQ-044 Send a 20-word frame (payload 1..20, trailer 210) while toggling m_axis_tready 1-cycle-on/1-off -> 20 in-order words with no loss or duplication, and tdata stable while stalled.
REQ-045 Assert rst_glbl after the 2nd payload word of a 5-word frame, then send a complete 2-word frame -> no pulse from the aborted frame; the new frame completes with frame_cnt=1.
REQ-046 Send two back-to-back valid frames with no idle cycle -> both produce frame_done, with frame_cnt=2.
